rll_key_loader: RTL and testbench
=================================

Name: rll_key_loader

Overview:
- Sequences key delivery into an RLL-locked combinational netlist (32-bit keyIn bus).
- Accepts the key as CHUNK_W-bit beats over a valid/ready stream, assembles it in a shadow register, then commits it atomically to the key bus.
- Exposes armed/error status so downstream logic can qualify the locked netlist's outputs.
- Sits between the on-chip key store / test access port and the locked netlist.

Parameters:
- KEY_W, 32, key width; must be a multiple of CHUNK_W.
- CHUNK_W, 8, bits per input beat.
- NBEATS, KEY_W/CHUNK_W, derived beat count; not user-set.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- load_start  in  1  pulse; begins a key load.
- zeroize  in  1  pulse; clears the committed key.
- key_valid  in  1  beat valid.
- key_data  in  CHUNK_W  beat payload, LSB chunk first.
- key_ready  out  1  beat accepted when key_valid && key_ready.
- key_out  out  KEY_W  drives keyIn_0_0..keyIn_0_{KEY_W-1}; bit i = keyIn_0_i.
- armed  out  1  key_out holds a committed key.
- busy  out  1  load in progress.
- error  out  1  sticky load error; cleared by load_start, zeroize or rst.

Behaviour:
- Reset: the FSM enters IDLE. key_out=0, shadow=0, beat_cnt=0, key_ready=0, armed=0, busy=0, error=0.
- States: IDLE, LOAD, COMMIT, ARMED (plus CHECK when the optional feature is enabled).
- IDLE or ARMED, load_start=1: go to LOAD next cycle. Clear shadow, beat_cnt and error. key_out and armed keep their prior values until commit.
- LOAD:
  - key_ready=1, busy=1.
  - On each handshake: shadow[beat_cnt*CHUNK_W +: CHUNK_W] <= key_data; beat_cnt++.
  - The handshake with beat_cnt==NBEATS-1 goes to COMMIT.
  - key_valid low inserts a stall; there is no timeout.
- COMMIT, one cycle:
  - key_ready=0.
  - key_out <= shadow; armed=1 from the next cycle; then go to ARMED.
  - Latency: last handshake at cycle t gives key_out updated and armed=1 at t+2.
- ARMED: key_ready=0, busy=0. key_out is stable until the next commit or zeroize.
- zeroize:
  - Highest priority in every state.
  - Next cycle: key_out=0, shadow=0, beat_cnt=0, armed=0, error=0, state IDLE.
  - Any in-progress load is abandoned.
- load_start during LOAD: restarts the load. Shadow and beat_cnt clear; the beat presented that cycle is NOT accepted (key_ready forced 0 that cycle).
- load_start and zeroize in the same cycle: zeroize wins, and load_start is dropped.
- Beats arriving while not in LOAD are ignored (key_ready=0).
- beat_cnt width is clog2(NBEATS+1). It never wraps; COMMIT is entered exactly at NBEATS.
- rst mid-load: identical to the reset values above.

Optional Feature:
- Macro: RLL_KEY_LOADER_CHECKSUM_EN.
- Enabled:
  - After NBEATS key beats, LOAD accepts one extra CHUNK_W checksum beat.
  - The state then moves to CHECK (1 cycle).
  - CHECK compares the received beat with the XOR of all NBEATS key chunks.
  - Match: go to COMMIT.
  - Mismatch: error=1, shadow cleared, key_out/armed unchanged, return to IDLE if previously unarmed, otherwise ARMED.
  - Added latency: +2 cycles (extra beat plus CHECK).
- Disabled: no CHECK state and no checksum beat; error is tied 0.

Decomposition:
- Package rll_key_pkg:
  - KEY_W and CHUNK_W defaults.
  - The state enum typedef.
  - The checksum function (XOR-fold of KEY_W into CHUNK_W).
- Sub-module rll_key_shadow: the shadow register with indexed chunk write, clear and commit-to-output register. The FSM lives in the top.

Test Plan:
- Basic load: rst; load_start; beats 0x11,0x22,0x33,0x44 back-to-back -> key_out=0x44332211 and armed=1 exactly 2 cycles after the 4th handshake; busy low from the same cycle.
- Stalled load: key_valid toggles 1/0 per cycle for the beats 0xA5,0x5A,0xFF,0x00 -> key_out=0x00FF5AA5. Exactly 4 handshakes are counted; no beat is duplicated.
- Reload while armed: armed with 0x44332211; load 0xDEADBEEF -> key_out stays 0x44332211 until commit, then becomes 0xDEADBEEF; armed never drops.
- Zeroize mid-load: after 2 beats, zeroize and load_start together -> next cycle key_out=0, armed=0, state IDLE, key_ready=0.
- Restart mid-load: after 3 beats, load_start with key_valid=1 -> that beat is rejected; 4 fresh beats then commit the new key only.
- Checksum (macro on): beats 0x01,0x02,0x04,0x08 with checksum 0x0F -> commit 0x08040201. With checksum 0x0E -> error=1, armed and key_out unchanged.

Source files
------------

// File: rtl/rll_key_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rll_key_pkg
// Description : Shared widths, FSM state encoding and the key checksum fold
//               used by the RLL key loader. The checksum is only consumed
//               when RLL_KEY_LOADER_CHECKSUM_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
package rll_key_pkg;

    localparam int unsigned RLL_KEY_W      = 32;
    localparam int unsigned RLL_CHUNK_W    = 8;
    // Widest key the checksum fold can handle (8-bit internal bit index).
    localparam int unsigned RLL_FOLD_MAX_W = 256;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_COMMIT = 3'd2,
        ST_ARMED  = 3'd3,
        ST_CHECK  = 3'd4
    } rll_state_e;

    // XOR-fold the low key_w bits of key into chunk_w bits; bit i of the key
    // lands on bit (i mod chunk_w), which equals XOR of all key chunks.
    function automatic logic [RLL_FOLD_MAX_W-1:0] rll_checksum(
        input logic [RLL_FOLD_MAX_W-1:0] key,
        input int unsigned               key_w,
        input int unsigned               chunk_w
    );
        logic [RLL_FOLD_MAX_W-1:0] fold;
        int unsigned               pos;
        fold = '0;
        for (int unsigned i = 0; i < RLL_FOLD_MAX_W; i++) begin
            if (i < key_w) begin
                pos = i % chunk_w;
                fold[pos[7:0]] = fold[pos[7:0]] ^ key[i[7:0]];
            end
        end
        return fold;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rll_key_shadow.sv
`default_nettype none
// ============================================================================
// Module      : rll_key_shadow
// Description : Shadow key register with per-chunk indexed write and clear,
//               plus the committed key output register. With
//               RLL_KEY_LOADER_CHECKSUM_EN defined it also exposes the XOR
//               fold of the shadow contents.
// Revision    : 1.0 - initial release
// ============================================================================
module rll_key_shadow
    import rll_key_pkg::*;
#(
    parameter  int unsigned KEY_W   = RLL_KEY_W,
    parameter  int unsigned CHUNK_W = RLL_CHUNK_W,
    localparam int unsigned NBEATS  = KEY_W / CHUNK_W,
    localparam int unsigned CNT_W   = $clog2(NBEATS + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               wr_en,
    input  logic [CNT_W-1:0]   wr_idx,
    input  logic [CHUNK_W-1:0] wr_data,
    input  logic               commit,
    input  logic               zero_out,
`ifdef RLL_KEY_LOADER_CHECKSUM_EN
    output logic [CHUNK_W-1:0] fold,
`endif
    output logic [KEY_W-1:0]   key_out
);

    logic [KEY_W-1:0] shadow_q, shadow_d;
    logic [KEY_W-1:0] key_out_q, key_out_d;

    // Next shadow: clear wins over a chunk write; only the addressed chunk changes.
    always_comb begin
        shadow_d = shadow_q;
        if (clear) begin
            shadow_d = '0;
        end else if (wr_en) begin
            for (int unsigned c = 0; c < NBEATS; c++) begin
                if (wr_idx == CNT_W'(c)) begin
                    shadow_d[c*CHUNK_W +: CHUNK_W] = wr_data;
                end
            end
        end
    end

    // Next committed key: zeroize clears it, commit copies the whole shadow at once.
    always_comb begin
        key_out_d = key_out_q;
        if (zero_out) begin
            key_out_d = '0;
        end else if (commit) begin
            key_out_d = shadow_q;
        end
    end

    // Shadow and committed key registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q  <= '0;
            key_out_q <= '0;
        end else begin
            shadow_q  <= shadow_d;
            key_out_q <= key_out_d;
        end
    end

    assign key_out = key_out_q;

`ifdef RLL_KEY_LOADER_CHECKSUM_EN
    assign fold = CHUNK_W'(rll_checksum(RLL_FOLD_MAX_W'(shadow_q), KEY_W, CHUNK_W));
`endif

endmodule
`default_nettype wire

// File: rtl/rll_key_loader.sv
`default_nettype none
// ============================================================================
// Module      : rll_key_loader
// Description : Assembles a key from CHUNK_W-bit valid/ready beats (LSB chunk
//               first) and commits it atomically to the key bus of an
//               RLL-locked netlist. Reports armed/busy/error status.
//               Optional: RLL_KEY_LOADER_CHECKSUM_EN adds a trailing XOR
//               checksum beat verified in a CHECK state before commit.
//               KEY_W must be an integer multiple of CHUNK_W.
// Revision    : 1.0 - initial release
// ============================================================================
module rll_key_loader
    import rll_key_pkg::*;
#(
    parameter  int unsigned KEY_W   = RLL_KEY_W,
    parameter  int unsigned CHUNK_W = RLL_CHUNK_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_start,
    input  logic               zeroize,
    input  logic               key_valid,
    input  logic [CHUNK_W-1:0] key_data,
    output logic               key_ready,
    output logic [KEY_W-1:0]   key_out,
    output logic               armed,
    output logic               busy,
    output logic               error
);

    localparam int unsigned NBEATS = KEY_W / CHUNK_W;
    localparam int unsigned CNT_W  = $clog2(NBEATS + 1);

    rll_state_e       state_q, state_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic             armed_q, armed_d;
    logic             busy_q, busy_d;

    logic             handshake;
    logic             sh_clear;
    logic             sh_wr;
    logic             sh_commit;
    logic             key_zero;

`ifdef RLL_KEY_LOADER_CHECKSUM_EN
    logic [CHUNK_W-1:0] csum_q, csum_d;
    logic               error_q, error_d;
    logic [CHUNK_W-1:0] shadow_fold;
`endif

    // A restart or zeroize in LOAD refuses the beat presented in that cycle.
    assign key_ready = (state_q == ST_LOAD) && !load_start && !zeroize;
    assign handshake = key_valid && key_ready;

    // Next-state and control decode; zeroize overrides every state and load_start.
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        armed_d    = armed_q;
        sh_clear   = 1'b0;
        sh_wr      = 1'b0;
        sh_commit  = 1'b0;
        key_zero   = 1'b0;
`ifdef RLL_KEY_LOADER_CHECKSUM_EN
        csum_d     = csum_q;
        error_d    = error_q;
`endif
        if (zeroize) begin
            state_d    = ST_IDLE;
            beat_cnt_d = '0;
            armed_d    = 1'b0;
            sh_clear   = 1'b1;
            key_zero   = 1'b1;
`ifdef RLL_KEY_LOADER_CHECKSUM_EN
            error_d    = 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE, ST_ARMED: begin
                    if (load_start) begin
                        state_d    = ST_LOAD;
                        beat_cnt_d = '0;
                        sh_clear   = 1'b1;
`ifdef RLL_KEY_LOADER_CHECKSUM_EN
                        error_d    = 1'b0;
`endif
                    end
                end
                ST_LOAD: begin
                    if (load_start) begin
                        beat_cnt_d = '0;
                        sh_clear   = 1'b1;
`ifdef RLL_KEY_LOADER_CHECKSUM_EN
                        error_d    = 1'b0;
`endif
                    end else if (handshake) begin
                        if (beat_cnt_q < CNT_W'(NBEATS)) begin
                            sh_wr      = 1'b1;
                            beat_cnt_d = beat_cnt_q + CNT_W'(1);
`ifndef RLL_KEY_LOADER_CHECKSUM_EN
                            if (beat_cnt_q == CNT_W'(NBEATS - 1)) begin
                                state_d = ST_COMMIT;
                            end
`endif
                        end
`ifdef RLL_KEY_LOADER_CHECKSUM_EN
                        else begin
                            // Trailing beat after the full key is the checksum.
                            csum_d  = key_data;
                            state_d = ST_CHECK;
                        end
`endif
                    end
                end
`ifdef RLL_KEY_LOADER_CHECKSUM_EN
                ST_CHECK: begin
                    if (shadow_fold == csum_q) begin
                        state_d = ST_COMMIT;
                    end else begin
                        error_d  = 1'b1;
                        sh_clear = 1'b1;
                        state_d  = armed_q ? ST_ARMED : ST_IDLE;
                    end
                end
`endif
                ST_COMMIT: begin
                    sh_commit = 1'b1;
                    armed_d   = 1'b1;
                    state_d   = ST_ARMED;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        busy_d = (state_d == ST_LOAD) || (state_d == ST_COMMIT) || (state_d == ST_CHECK);
    end

    // Single FSM register bank; status outputs are registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            beat_cnt_q <= '0;
            armed_q    <= 1'b0;
            busy_q     <= 1'b0;
`ifdef RLL_KEY_LOADER_CHECKSUM_EN
            csum_q     <= '0;
            error_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            armed_q    <= armed_d;
            busy_q     <= busy_d;
`ifdef RLL_KEY_LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
            error_q    <= error_d;
`endif
        end
    end

    rll_key_shadow #(
        .KEY_W   (KEY_W),
        .CHUNK_W (CHUNK_W)
    ) u_shadow (
        .clk      (clk),
        .rst      (rst),
        .clear    (sh_clear),
        .wr_en    (sh_wr),
        .wr_idx   (beat_cnt_q),
        .wr_data  (key_data),
        .commit   (sh_commit),
        .zero_out (key_zero),
`ifdef RLL_KEY_LOADER_CHECKSUM_EN
        .fold     (shadow_fold),
`endif
        .key_out  (key_out)
    );

    assign armed = armed_q;
    assign busy  = busy_q;

`ifdef RLL_KEY_LOADER_CHECKSUM_EN
    assign error = error_q;
`else
    assign error = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rll_key_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_rll_key_loader
// Description : Directed self-checking bench for rll_key_loader (default
//               32-bit key, 8-bit beats). The checksum scenario is built
//               when RLL_KEY_LOADER_CHECKSUM_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rll_key_loader;

    logic        clk        = 1'b0;
    logic        rst        = 1'b1;
    logic        load_start = 1'b0;
    logic        zeroize    = 1'b0;
    logic        key_valid  = 1'b0;
    logic [7:0]  key_data   = 8'h00;
    logic        key_ready;
    logic [31:0] key_out;
    logic        armed;
    logic        busy;
    logic        error;

    int checks   = 0;
    int failures = 0;
    int hs_cnt   = 0;

    rll_key_loader #(
        .KEY_W   (32),
        .CHUNK_W (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .zeroize    (zeroize),
        .key_valid  (key_valid),
        .key_data   (key_data),
        .key_ready  (key_ready),
        .key_out    (key_out),
        .armed      (armed),
        .busy       (busy),
        .error      (error)
    );

    always #5 clk = ~clk;

    // Count accepted beats.
    always @(posedge clk) begin
        if (key_valid && key_ready) hs_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    // Present one beat and hold it until accepted (bounded wait).
    task automatic beat(input logic [7:0] d);
        int waited = 0;
        key_valid = 1'b1;
        key_data  = d;
        #1;
        while (!key_ready && waited < 20) begin
            tick();
            waited++;
        end
        check("beat_ready", {31'b0, key_ready}, 32'd1);
        if (key_ready) begin
            @(posedge clk);
            #2;
        end
        key_valid = 1'b0;
    endtask

    logic [7:0] stall_beats [4];

    initial begin
        stall_beats[0] = 8'hA5;
        stall_beats[1] = 8'h5A;
        stall_beats[2] = 8'hFF;
        stall_beats[3] = 8'h00;

        // Reset values
        repeat (3) tick();
        rst = 1'b0;
        check("rst_key_out", key_out, 32'h0);
        check("rst_armed", {31'b0, armed}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_error", {31'b0, error}, 32'd0);

        // Beat while idle is refused
        key_valid = 1'b1;
        key_data  = 8'h77;
        #1;
        check("idle_ready", {31'b0, key_ready}, 32'd0);
        key_valid = 1'b0;
        tick();

        // Basic load: commit visible 2 cycles after last handshake
        pulse_start();
        check("basic_busy", {31'b0, busy}, 32'd1);
        beat(8'h11); beat(8'h22); beat(8'h33); beat(8'h44);
        check("basic_pre_armed", {31'b0, armed}, 32'd0);
        check("basic_pre_key", key_out, 32'h0);
        check("basic_commit_ready", {31'b0, key_ready}, 32'd0);
        tick();
        check("basic_key", key_out, 32'h44332211);
        check("basic_armed", {31'b0, armed}, 32'd1);
        check("basic_busy_lo", {31'b0, busy}, 32'd0);

        // Reload while armed: old key held until commit
        pulse_start();
        check("reload_armed0", {31'b0, armed}, 32'd1);
        check("reload_key0", key_out, 32'h44332211);
        beat(8'hEF); beat(8'hBE); beat(8'hAD); beat(8'hDE);
        check("reload_armed1", {31'b0, armed}, 32'd1);
        check("reload_key1", key_out, 32'h44332211);
        tick();
        check("reload_key2", key_out, 32'hDEADBEEF);
        check("reload_armed2", {31'b0, armed}, 32'd1);

        // Stalled load: valid toggles per cycle
        pulse_start();
        hs_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            key_valid = 1'b1;
            key_data  = stall_beats[i];
            tick();
            key_valid = 1'b0;
            key_data  = 8'hEE;
            tick();
        end
        check("stall_key", key_out, 32'h00FF5AA5);
        check("stall_hs", 32'(hs_cnt), 32'd4);

        // Zeroize together with load_start mid-load
        pulse_start();
        beat(8'h01); beat(8'h02);
        zeroize    = 1'b1;
        load_start = 1'b1;
        key_valid  = 1'b1;
        key_data   = 8'h03;
        #1;
        check("zero_ready_same", {31'b0, key_ready}, 32'd0);
        tick();
        zeroize    = 1'b0;
        load_start = 1'b0;
        #1;
        check("zero_key", key_out, 32'h0);
        check("zero_armed", {31'b0, armed}, 32'd0);
        check("zero_ready", {31'b0, key_ready}, 32'd0);
        check("zero_busy", {31'b0, busy}, 32'd0);
        tick();
        check("zero_still_idle", {31'b0, busy}, 32'd0);
        key_valid = 1'b0;

        // Restart mid-load: the beat presented with load_start is refused
        pulse_start();
        beat(8'h10); beat(8'h20); beat(8'h30);
        load_start = 1'b1;
        key_valid  = 1'b1;
        key_data   = 8'h99;
        #1;
        check("restart_ready", {31'b0, key_ready}, 32'd0);
        tick();
        load_start = 1'b0;
        key_valid  = 1'b0;
        check("restart_busy", {31'b0, busy}, 32'd1);
        beat(8'hC1); beat(8'hC2); beat(8'hC3); beat(8'hC4);
        tick();
        check("restart_key", key_out, 32'hC4C3C2C1);
        check("restart_armed", {31'b0, armed}, 32'd1);

        // Reset in the middle of a load
        pulse_start();
        beat(8'h55);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_key", key_out, 32'h0);
        check("midrst_armed", {31'b0, armed}, 32'd0);
        check("midrst_busy", {31'b0, busy}, 32'd0);

`ifdef RLL_KEY_LOADER_CHECKSUM_EN
        // Good checksum: 01^02^04^08 = 0F
        pulse_start();
        beat(8'h01); beat(8'h02); beat(8'h04); beat(8'h08); beat(8'h0F);
        check("csum_busy", {31'b0, busy}, 32'd1);
        tick();
        tick();
        check("csum_key", key_out, 32'h08040201);
        check("csum_armed", {31'b0, armed}, 32'd1);
        check("csum_err0", {31'b0, error}, 32'd0);
        // Bad checksum: key and armed unchanged, sticky error set
        pulse_start();
        beat(8'h10); beat(8'h20); beat(8'h40); beat(8'h80); beat(8'h0E);
        tick();
        check("csum_err1", {31'b0, error}, 32'd1);
        check("csum_bad_armed", {31'b0, armed}, 32'd1);
        tick();
        check("csum_bad_key", key_out, 32'h08040201);
        check("csum_err_sticky", {31'b0, error}, 32'd1);
        pulse_start();
        check("csum_err_clr", {31'b0, error}, 32'd0);
`else
        check("no_csum_error", {31'b0, error}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
